// File: rtl/snes_pkg.sv
// Shared constants for the SNES poll scheduler: reader bit positions, stable-vector
// indices, event field layout, FSM encoding and the debug view of the scheduler.
package snes_pkg;

    localparam int RD_B     = 0;
    localparam int RD_UP    = 4;
    localparam int RD_DOWN  = 5;
    localparam int RD_LEFT  = 6;
    localparam int RD_RIGHT = 7;
    localparam int RD_A     = 8;

    localparam int BTN_B     = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;
    localparam int BTN_A     = 5;
    localparam int NUM_BTN   = 6;

    localparam int EVT_PRESS   = 3;
    localparam int EVT_IDX_MSB = 2;
    localparam int EVT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EVAL = 3'd3,
        ST_EMIT = 3'd4
    } state_e;

    typedef struct packed {
        state_e     state;
        logic       fifo_full;
        logic [2:0] scan_idx;
    } dbg_t;

endpackage

// File: rtl/snes_poll_scheduler_if.sv
// Start/done handshake between the scheduler (master) and the SNES reader (slave).
interface snes_poll_scheduler_if;
    // poll_start is a one-cycle request; the reader answers later with a one-cycle
    // poll_done pulse, and poll_data is only meaningful in that same cycle.
    logic        poll_start;
    logic        poll_done;
    logic [11:0] poll_data;

    modport master (output poll_start, input poll_done, input poll_data);
    modport slave  (input poll_start, output poll_done, output poll_data);
endinterface

// File: rtl/snes_event_fifo.sv
// First-word fall-through event FIFO with occupancy count and sticky overflow flag.
module snes_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    input  logic             ovf_clr,
    output logic             overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/snes_poll_scheduler.sv
// Periodically polls the SNES reader, debounces the returned buttons and queues
// press/release events for the CPU.
module snes_poll_scheduler
    import snes_pkg::*;
#(
    parameter int POLL_PERIOD = 833333,
    parameter int TIMEOUT     = 4096,
    parameter int DEBOUNCE    = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    snes_poll_scheduler_if.master        rdr,
    output logic [NUM_BTN-1:0]           stable_buttons,
    output logic                         evt_valid,
    output logic [EVT_W-1:0]             evt_data,
    input  logic                         evt_rd,
    output logic                         evt_overflow,
    input  logic                         ovf_clr,
    output logic                         timeout_err,
    output dbg_t                         dbg
);
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE);

    state_e               state, state_nx;
    logic [PW-1:0]        per_cnt;
    logic                 tick;
    logic [TW-1:0]        to_cnt, to_nx;
    logic [NUM_BTN-1:0]   sample, sample_nx;
    logic [NUM_BTN-1:0]   cand, cand_nx, cand_eval;
    logic [3:0]           db_cnt, db_nx, db_eval;
    logic [NUM_BTN-1:0]   stable, stable_nx;
    logic [NUM_BTN-1:0]   diff, diff_nx;
    logic [2:0]           scan_idx, idx_nx;
    logic                 terr_nx;
    logic                 poll_start;
    logic                 push;
    logic [EVT_W-1:0]     push_data;
    logic [NUM_BTN-1:0]   sample_in;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 unused_data_bits;

    assign sample_in = {rdr.poll_data[RD_A], rdr.poll_data[RD_RIGHT], rdr.poll_data[RD_LEFT],
                        rdr.poll_data[RD_DOWN], rdr.poll_data[RD_UP], rdr.poll_data[RD_B]};
    assign unused_data_bits = ^{rdr.poll_data[11:9], rdr.poll_data[3:1]};

    // Period counter is parked at 0 while disabled so re-enabling gives a full period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_cnt <= '0;
        end else if (!enable || per_cnt == PW'(POLL_PERIOD - 1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end
    assign tick = enable && (per_cnt == PW'(POLL_PERIOD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            sample      <= '0;
            cand        <= '0;
            db_cnt      <= '0;
            stable      <= '0;
            diff        <= '0;
            scan_idx    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            to_cnt      <= to_nx;
            sample      <= sample_nx;
            cand        <= cand_nx;
            db_cnt      <= db_nx;
            stable      <= stable_nx;
            diff        <= diff_nx;
            scan_idx    <= idx_nx;
            timeout_err <= terr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        to_nx      = to_cnt;
        sample_nx  = sample;
        cand_nx    = cand;
        db_nx      = db_cnt;
        stable_nx  = stable;
        diff_nx    = diff;
        idx_nx     = scan_idx;
        terr_nx    = timeout_err;
        cand_eval  = cand;
        db_eval    = db_cnt;
        poll_start = 1'b0;
        push       = 1'b0;
        push_data  = '0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                poll_start = 1'b1;
                to_nx      = TW'(TIMEOUT - 1);
                state_nx   = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last timeout cycle still counts.
                if (rdr.poll_done) begin
                    sample_nx = sample_in;
                    terr_nx   = 1'b0;
                    state_nx  = ST_EVAL;
                end else if (to_cnt == '0) begin
                    terr_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    to_nx = to_cnt - 1'b1;
                end
            end
            ST_EVAL: begin
                if (sample == cand) begin
                    db_eval = (db_cnt >= DB) ? DB : db_cnt + 1'b1;
                end else begin
                    cand_eval = sample;
                    db_eval   = 4'd1;
                end
                cand_nx = cand_eval;
                db_nx   = db_eval;
                if (db_eval == DB && cand_eval != stable) begin
                    diff_nx   = cand_eval ^ stable;
                    stable_nx = cand_eval;
                    idx_nx    = '0;
                    state_nx  = ST_EMIT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_EMIT: begin
                push      = diff[scan_idx];
                push_data = {stable[scan_idx], scan_idx};
                if (scan_idx == 3'(NUM_BTN - 1)) begin
                    state_nx = ST_IDLE;
                end else begin
                    idx_nx = scan_idx + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    snes_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (push_data),
        .pop      (evt_rd),
        .dout     (evt_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .ovf_clr  (ovf_clr),
        .overflow (evt_overflow)
    );

    assign rdr.poll_start = poll_start;
    assign stable_buttons = stable;
    assign evt_valid      = !fifo_empty;
    assign dbg            = '{state: state, fifo_full: fifo_full, scan_idx: scan_idx};

endmodule
